// File: rtl/rom_loader.sv
// ROM download loader: buffers ioctl ROM bytes, maps 16K pages to SDRAM banks,
// issues acknowledged boot writes and holds system reset until loading settles.
module rom_loader #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        mem_ack,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [7:0]  boot_dout,
  output logic        reset_out,
  output logic        load_done,
  output logic        overflow,
  output logic [15:0] dropped_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef struct packed {
    logic [22:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          rom_dl, rom_dl_q, dl_rise;
  logic          enter_load, done_d;

  entry_t        mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full;
  logic [10:0]   page;
  logic [8:0]    bank;
  logic          wr_evt, in_range, push, pop, lost, drop;
  entry_t        push_entry, head;

  assign rom_dl  = ioctl_download & (ioctl_index == 8'd0);
  assign dl_rise = rom_dl & ~rom_dl_q;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign page     = ioctl_addr[24:14];
  assign in_range = (page <= 11'd2);
  assign wr_evt   = (state == LOAD) & rom_dl & ioctl_wr;
  assign pop      = ~boot_wr & ~empty & ((state == LOAD) | (state == DRAIN));
  // A pop in the same cycle frees the slot a push on a full FIFO needs
  assign push     = wr_evt & in_range & (~full | pop);
  assign lost     = wr_evt & in_range & full & ~pop;
  assign drop     = wr_evt & ~in_range;

  always_comb begin
    bank = 9'h000;
    case (page[1:0])
      2'd0:    bank = 9'h000;
      2'd1:    bank = 9'h100;
      default: bank = 9'h107;
    endcase
  end

  assign push_entry = '{addr: {bank, ioctl_addr[13:0]}, data: ioctl_dout};
  assign head       = mem[rd_ptr[AW-1:0]];

  // Next-state logic; a new download during HOLD abandons the settle count
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    done_d     = 1'b0;
    enter_load = 1'b0;
    case (state)
      IDLE: begin
        if (dl_rise) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        if (!rom_dl) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty && !boot_wr) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (dl_rise) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end else if (cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rom_dl_q  <= 1'b0;
      reset_out <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rom_dl_q  <= rom_dl;
      reset_out <= (state_d != IDLE);
      load_done <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // FIFO pointers, SDRAM write handshake and download statistics
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      boot_wr     <= 1'b0;
      boot_a      <= '0;
      boot_dout   <= '0;
      overflow    <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        boot_wr   <= 1'b1;
        boot_a    <= head.addr;
        boot_dout <= head.data;
      end else if (boot_wr && mem_ack) begin
        boot_wr <= 1'b0;
      end
      if (enter_load)  overflow <= 1'b0;
      else if (lost)   overflow <= 1'b1;
      if (enter_load) dropped_cnt <= '0;
      else if (drop && dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed downloads, expected SDRAM writes
// queued at stimulus time and compared by an independent write monitor.
module tb_rom_loader;

  localparam int unsigned HOLD = 20;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_ack = 1'b0;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [7:0]  boot_dout;
  logic        reset_out;
  logic        load_done;
  logic        overflow;
  logic [15:0] dropped_cnt;

  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  bit          ack_en = 1'b0;
  logic        bw_prev = 1'b0;
  logic [30:0] mon_exp;
  logic [30:0] sb [$];

  rom_loader #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RESET_n(RESET_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .mem_ack(mem_ack), .boot_wr(boot_wr), .boot_a(boot_a), .boot_dout(boot_dout),
    .reset_out(reset_out), .load_done(load_done), .overflow(overflow),
    .dropped_cnt(dropped_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM model: acknowledge one cycle after the request is seen
  always begin
    @(posedge CLK);
    #1;
    mem_ack = ack_en && boot_wr && !mem_ack;
  end

  // Monitor: every new write request is matched against the scoreboard head
  always begin
    @(posedge CLK);
    #1;
    if (boot_wr && !bw_prev) begin
      wr_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got a=0x%0h d=0x%0h expected no write", boot_a, boot_dout);
      end else begin
        mon_exp = sb.pop_front();
        chk("write_addr", 32'(boot_a), 32'(mon_exp[30:8]));
        chk("write_data", 32'(boot_dout), 32'(mon_exp[7:0]));
      end
    end
    bw_prev = boot_wr;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge CLK);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    @(negedge CLK);
    ioctl_download = 1'b0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d,
                         input logic [22:0] ea, input bit expect_it);
    @(negedge CLK);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (expect_it) sb.push_back({ea, d});
    @(negedge CLK);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int n);
    int t = 0;
    while ((wr_count < n || boot_wr) && t < 2000) begin
      @(negedge CLK);
      t++;
    end
    chk(name, 32'(wr_count), 32'(n));
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!load_done && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    chk(name, 32'(load_done), 32'd1);
    chk({name, "_rst"}, 32'(reset_out), 32'd0);
  endtask

  initial begin
    int n;
    int lowrst;
    int pulses;

    // Reset values
    cyc(3);
    chk("rst_boot_wr", 32'(boot_wr), 32'd0);
    chk("rst_boot_a", 32'(boot_a), 32'd0);
    chk("rst_boot_dout", 32'(boot_dout), 32'd0);
    chk("rst_reset_out", 32'(reset_out), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dropped", 32'(dropped_cnt), 32'd0);
    @(negedge CLK);
    RESET_n = 1'b1;
    cyc(2);

    // Page mapping for pages 0, 1, 2
    ack_en = 1'b1;
    start_dl(8'd0);
    @(negedge CLK);
    chk("t1_reset_out", 32'(reset_out), 32'd1);
    wr_byte(25'h0000000, 8'hAA, 23'h000000, 1'b1);
    wr_byte(25'h0004001, 8'h55, 23'h400001, 1'b1);
    wr_byte(25'h0008002, 8'h77, 23'h41C002, 1'b1);
    wait_writes("t1_writes", 3);
    end_dl();
    wait_done("t1_done");

    // Overflow with mem_ack withheld: 1 in flight + 4 queued, 6th lost
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 6; i++)
      wr_byte(25'(16 + i), 8'(16 + i), 23'(16 + i), (i < 5));
    cyc(2);
    chk("t3_inflight", 32'(wr_count), 32'd4);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_boot_wr", 32'(boot_wr), 32'd1);
    ack_en = 1'b1;
    wait_writes("t3_writes", 8);
    cyc(10);
    chk("t3_no_extra", 32'(wr_count), 32'd8);
    end_dl();
    wait_done("t3_done");

    // Pages above 2 are dropped and counted, saturating
    start_dl(8'd0);
    @(negedge CLK);
    chk("t2_ovf_clr", 32'(overflow), 32'd0);
    wr_byte(25'h000C000, 8'hEE, 23'h0, 1'b0);
    cyc(3);
    chk("t2_dropped1", 32'(dropped_cnt), 32'd1);
    chk("t2_no_write", 32'(wr_count), 32'd8);
    @(negedge CLK);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h1FFFFFF;
    repeat (65540) @(negedge CLK);
    ioctl_wr = 1'b0;
    cyc(1);
    chk("t2_saturate", 32'(dropped_cnt), 32'h0000FFFF);
    chk("t2_no_write2", 32'(wr_count), 32'd8);
    end_dl();
    wait_done("t2_done");

    // Drain + hold timing of reset_out and a single load_done pulse
    ack_en = 1'b0;
    start_dl(8'd0);
    @(negedge CLK);
    chk("t4_drop_clr", 32'(dropped_cnt), 32'd0);
    for (int i = 0; i < 4; i++)
      wr_byte(25'(32'h4100 + i), 8'(8'hC0 + i), 23'(32'h400100 + i), 1'b1);
    end_dl();
    cyc(5);
    chk("t4_drain_rst", 32'(reset_out), 32'd1);
    chk("t4_inflight", 32'(wr_count), 32'd9);
    ack_en = 1'b1;
    wait_writes("t4_writes", 12);
    n = 0;
    lowrst = 0;
    while (!load_done && n < 5000) begin
      if (!reset_out) lowrst++;
      n++;
      @(negedge CLK);
    end
    chk("t4_hold_len", 32'(n), 32'(HOLD + 1));
    chk("t4_rst_low", 32'(lowrst), 32'd0);
    chk("t4_done", 32'(load_done), 32'd1);
    chk("t4_done_rst", 32'(reset_out), 32'd0);
    @(negedge CLK);
    chk("t4_done_pulse", 32'(load_done), 32'd0);
    pulses = 0;
    repeat (10) begin
      @(negedge CLK);
      if (load_done) pulses++;
    end
    chk("t4_one_pulse", 32'(pulses), 32'd0);

    // Non-ROM index is ignored
    start_dl(8'd1);
    @(negedge CLK);
    chk("t5_reset_out", 32'(reset_out), 32'd0);
    wr_byte(25'h0000000, 8'h12, 23'h0, 1'b0);
    wr_byte(25'h0004000, 8'h13, 23'h0, 1'b0);
    cyc(5);
    chk("t5_reset_out2", 32'(reset_out), 32'd0);
    chk("t5_no_write", 32'(wr_count), 32'd12);
    end_dl();
    cyc(2);
    ioctl_index = 8'd0;
    cyc(2);

    // Asynchronous reset mid-write, then a clean download
    ack_en = 1'b0;
    start_dl(8'd0);
    wr_byte(25'h0000020, 8'h31, 23'h000020, 1'b1);
    wr_byte(25'h0000021, 8'h32, 23'h000021, 1'b0);
    cyc(2);
    chk("t6_busy", 32'(boot_wr), 32'd1);
    chk("t6_count", 32'(wr_count), 32'd13);
    @(negedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("t6_async_wr", 32'(boot_wr), 32'd0);
    chk("t6_async_rst", 32'(reset_out), 32'd0);
    chk("t6_async_a", 32'(boot_a), 32'd0);
    ioctl_download = 1'b0;
    sb.delete();
    cyc(2);
    @(negedge CLK);
    RESET_n = 1'b1;
    cyc(3);
    chk("t6_flushed", 32'(wr_count), 32'd13);
    ack_en = 1'b1;
    start_dl(8'd0);
    @(negedge CLK);
    chk("t6_reset_out", 32'(reset_out), 32'd1);
    wr_byte(25'h0004005, 8'h99, 23'h400005, 1'b1);
    wait_writes("t6_writes", 14);
    end_dl();
    wait_done("t6_done");
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
